fg_prog_sequencer: RTL

Sequencer for floating-gate programming of an island's EPOT/bias array. It accepts one programming command at a time: target row, target column, pulse count and pulse width. It then drives the island's programming mux through a fixed ordered sequence: vertical/horizontal Vinj decoders, drain-select and 4T-gate prog/drain-cutoff switches, and the injection pulse. It returns the island to run mode when done, so the analog array is never left half-configured.

---
 rtl/fg_prog_sequencer_if.sv | 38 +++
 rtl/fg_prog_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fg_prog_sequencer_if.sv
// Command and programming-mux bundle for the floating-gate programming sequencer.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; cmd_ready is high only in IDLE.
interface fg_prog_sequencer_if #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 2,
  parameter int CNT_W    = 8,
  parameter int PW_W     = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [ROW_BITS-1:0] cmd_row;
  logic [COL_BITS-1:0] cmd_col;
  logic [CNT_W-1:0]    cmd_pulses;
  logic [PW_W-1:0]     cmd_width;
  logic                abort;
  logic [ROW_BITS-1:0] row_addr;
  logic [COL_BITS-1:0] col_addr;
  logic                prog_mode;
  logic                dec_en;
  logic                vinj_pulse;
  logic                busy;
  logic                done;
  logic                aborted;
  logic [CNT_W-1:0]    pulses_sent;
  logic [2:0]          state_dbg;

  modport master (
    output cmd_valid, cmd_row, cmd_col, cmd_pulses, cmd_width, abort,
    input  cmd_ready, row_addr, col_addr, prog_mode, dec_en, vinj_pulse,
    input  busy, done, aborted, pulses_sent, state_dbg
  );

  modport slave (
    input  cmd_valid, cmd_row, cmd_col, cmd_pulses, cmd_width, abort,
    output cmd_ready, row_addr, col_addr, prog_mode, dec_en, vinj_pulse,
    output busy, done, aborted, pulses_sent, state_dbg
  );
endinterface

// File: rtl/fg_prog_sequencer.sv
// Steps one island through SETUP/SELECT/PULSE/GAP/RELEASE/DONE for a single programming command.
// Every output is registered from the next state, so the mux pins never glitch between phases.
module fg_prog_sequencer #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 2,
  parameter int CNT_W    = 8,
  parameter int PW_W     = 16,
  parameter int SETTLE   = 4,
  parameter int GAP      = 2
) (
  input logic clk,
  input logic rst,
  fg_prog_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SELECT, S_PULSE, S_GAP, S_RELEASE, S_DONE
  } state_t;

  localparam logic [PW_W-1:0] SETTLE_M1 = PW_W'(SETTLE - 1);
  localparam logic [PW_W-1:0] GAP_M1    = PW_W'(GAP - 1);

  state_t              state, nxt;
  logic [PW_W-1:0]     timer;
  logic [PW_W-1:0]     width_q;
  logic [CNT_W-1:0]    pulses_q;
  logic [CNT_W-1:0]    sent_q;
  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;
  logic                ready_q, busy_q, prog_q, dec_q, vinj_q, done_q, aborted_q;
  logic                timer_end, can_abort, take_abort;
  logic [CNT_W-1:0]    sent_inc;

  assign timer_end  = (timer == '0);
  assign can_abort  = (state == S_SETUP) || (state == S_SELECT) ||
                      (state == S_PULSE) || (state == S_GAP);
  assign take_abort = can_abort && bus.abort;
  assign sent_inc   = sent_q + CNT_W'(1);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (bus.cmd_valid) nxt = S_SETUP;
      S_SETUP:   if (take_abort) nxt = S_RELEASE;
                 else if (timer_end) nxt = S_SELECT;
      S_SELECT:  if (take_abort) nxt = S_RELEASE;
                 else if (timer_end) nxt = (pulses_q != '0) ? S_PULSE : S_RELEASE;
      S_PULSE:   if (take_abort) nxt = S_RELEASE;
                 else if (timer_end) nxt = (sent_inc < pulses_q) ? S_GAP : S_RELEASE;
      S_GAP:     if (take_abort) nxt = S_RELEASE;
                 else if (timer_end) nxt = S_PULSE;
      S_RELEASE: if (timer_end) nxt = S_DONE;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      width_q   <= '0;
      pulses_q  <= '0;
      sent_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      prog_q    <= 1'b0;
      dec_q     <= 1'b0;
      vinj_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state <= nxt;

      // Each phase loads its duration minus one on entry and counts down to zero.
      if (nxt != state) begin
        case (nxt)
          S_SETUP, S_SELECT, S_RELEASE: timer <= SETTLE_M1;
          S_PULSE:                      timer <= width_q - PW_W'(1);
          S_GAP:                        timer <= GAP_M1;
          default:                      timer <= '0;
        endcase
      end else if (!timer_end) begin
        timer <= timer - PW_W'(1);
      end

      if (state == S_IDLE && bus.cmd_valid) begin
        row_q     <= bus.cmd_row;
        col_q     <= bus.cmd_col;
        pulses_q  <= bus.cmd_pulses;
        width_q   <= (bus.cmd_width == '0) ? PW_W'(1) : bus.cmd_width;
        sent_q    <= '0;
        aborted_q <= 1'b0;
      end else if (state == S_PULSE && timer_end && !take_abort) begin
        sent_q <= sent_inc;
      end

      if (take_abort) aborted_q <= 1'b1;

      ready_q <= (nxt == S_IDLE);
      busy_q  <= (nxt != S_IDLE);
      prog_q  <= (nxt == S_SETUP) || (nxt == S_SELECT) || (nxt == S_PULSE) ||
                 (nxt == S_GAP) || (nxt == S_RELEASE);
      dec_q   <= (nxt == S_SELECT) || (nxt == S_PULSE) || (nxt == S_GAP);
      vinj_q  <= (nxt == S_PULSE);
      done_q  <= (nxt == S_DONE);
    end
  end

  assign bus.cmd_ready   = ready_q;
  assign bus.busy        = busy_q;
  assign bus.prog_mode   = prog_q;
  assign bus.dec_en      = dec_q;
  assign bus.vinj_pulse  = vinj_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.pulses_sent = sent_q;
  assign bus.row_addr    = row_q;
  assign bus.col_addr    = col_q;
  assign bus.state_dbg   = state;

endmodule
